// File: rtl/dcache_if.sv
// dcache_if: CPU, SRAM-array and memory signals of the L1 data-cache controller.
//   master: controller side (drives cpu_rdata/stall, sram_* controls, mem_* request)
//   slave : environment side (CPU, SRAM array, main memory)
interface dcache_if #(
  parameter int ADDR_W = 32,
  parameter int BLOCK_BYTES = 16,
  parameter int INDEX_W = 5
);
  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
  logic cpu_ren;
  logic cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0] cpu_byte_en;
  logic [31:0] cpu_rdata;
  logic stall;
  logic sram_ren;
  logic sram_wen;
  logic sram_mem_wen;
  logic [BLOCK_BYTES-1:0] sram_bytes_access;
  logic [TAG_W+INDEX_W-1:0] sram_block_addr;
  logic [8*BLOCK_BYTES-1:0] sram_data_in;
  logic sram_hit;
  logic sram_dirty;
  logic [8*BLOCK_BYTES-1:0] sram_data_out;
  logic [TAG_W-1:0] sram_victim_tag;
  logic mem_req;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [8*BLOCK_BYTES-1:0] mem_wdata;
  logic [8*BLOCK_BYTES-1:0] mem_rdata;
  logic mem_ack;
  modport master (
    input cpu_ren, cpu_wen, cpu_addr, cpu_wdata, cpu_byte_en,
    input sram_hit, sram_dirty, sram_data_out, sram_victim_tag,
    input mem_rdata, mem_ack,
    output cpu_rdata, stall,
    output sram_ren, sram_wen, sram_mem_wen, sram_bytes_access, sram_block_addr, sram_data_in,
    output mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output cpu_ren, cpu_wen, cpu_addr, cpu_wdata, cpu_byte_en,
    output sram_hit, sram_dirty, sram_data_out, sram_victim_tag,
    output mem_rdata, mem_ack,
    input cpu_rdata, stall,
    input sram_ren, sram_wen, sram_mem_wen, sram_bytes_access, sram_block_addr, sram_data_in,
    input mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: L1 data-cache miss handler (hit lookup, stall, dirty writeback, refill, install, replay).
//   clk, rst_n (async active-low), bus (dcache_if.master: CPU, SRAM array, memory),
//   hit_cnt / miss_cnt performance counters.
//   Define DCACHE_PERF_CNT_EN to build the counters; otherwise they are tied to zero.
module dcache_ctrl #(
  parameter int ADDR_W = 32,
  parameter int BLOCK_BYTES = 16,
  parameter int INDEX_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  dcache_if.master bus,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
  localparam int BA_W = TAG_W + INDEX_W;
  localparam int WORDS = BLOCK_BYTES / 4;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, INSTALL} state_t;
  state_t state, state_nx;
  logic [8*BLOCK_BYTES-1:0] victim_blk, refill_buf;
  logic [TAG_W-1:0] victim_tag;
  logic [BA_W-1:0] req_baddr, cpu_baddr;
  logic [31:0] rdata_w;
  logic [BLOCK_BYTES-1:0] byte_mask;
  logic req, idle, hit, miss;
  assign cpu_baddr = bus.cpu_addr[ADDR_W-1:OFF_W];
  assign req = bus.cpu_ren | bus.cpu_wen;
  assign idle = state == IDLE;
  assign hit = idle & req & bus.sram_hit;
  assign miss = idle & req & ~bus.sram_hit;
  // word select only exists when a block holds more than one word
  if (WORDS > 1) begin : g_wsel
    logic [OFF_W-3:0] w;
    assign w = bus.cpu_addr[OFF_W-1:2];
    assign rdata_w = bus.sram_data_out[32*w +: 32];
    assign byte_mask = BLOCK_BYTES'(bus.cpu_byte_en) << (4*w);
  end else begin : g_wsel
    assign rdata_w = bus.sram_data_out[31:0];
    assign byte_mask = BLOCK_BYTES'(bus.cpu_byte_en);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      victim_blk <= '0;
      victim_tag <= '0;
      req_baddr <= '0;
      refill_buf <= '0;
    end else begin
      if (miss) begin
        victim_blk <= bus.sram_data_out;
        victim_tag <= bus.sram_victim_tag;
        req_baddr <= cpu_baddr;
      end
      if (state == REFILL && bus.mem_ack) refill_buf <= bus.mem_rdata;
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (miss) state_nx = bus.sram_dirty ? WRITEBACK : REFILL;
      WRITEBACK: if (bus.mem_ack) state_nx = REFILL;
      REFILL:    if (bus.mem_ack) state_nx = INSTALL;
      default:   state_nx = IDLE;
    endcase
    bus.sram_ren = idle & bus.cpu_ren & ~bus.cpu_wen;
    bus.sram_wen = idle & bus.cpu_wen & bus.sram_hit;
    bus.sram_mem_wen = state == INSTALL;
    bus.sram_block_addr = idle ? cpu_baddr : req_baddr;
    bus.sram_bytes_access = idle ? byte_mask : '1;
    bus.sram_data_in = idle ? {WORDS{bus.cpu_wdata}} : refill_buf;
    bus.cpu_rdata = rdata_w;
    bus.stall = req & ~(idle & bus.sram_hit);
    bus.mem_req = state == WRITEBACK || state == REFILL;
    bus.mem_we = state == WRITEBACK;
    bus.mem_addr = state == WRITEBACK ? {victim_tag, req_baddr[INDEX_W-1:0], {OFF_W{1'b0}}}
                                      : {req_baddr, {OFF_W{1'b0}}};
    bus.mem_wdata = victim_blk;
  end
`ifdef DCACHE_PERF_CNT_EN
  // the first IDLE cycle after INSTALL is the replay of the missed access
  logic replay;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      replay <= 1'b0;
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      replay <= state == INSTALL;
      if (hit && !replay) hit_cnt <= hit_cnt + 32'd1;
      if (miss) miss_cnt <= miss_cnt + 32'd1;
    end
`else
  assign hit_cnt = '0;
  assign miss_cnt = '0;
`endif
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Miss-handling controller for the L1 data cache, sitting between the CPU memory stage and the data-cache SRAM array. It performs the hit lookup, stalls the pipeline on a miss, writes back a dirty victim, refills the block from main memory, installs it, and replays the access. All array state (valid/dirty/tag/PLRU) lives in the SRAM array; this block owns only sequencing and the memory handshake.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- BLOCK_BYTES, 16, bytes per cache block (power of 2, ≥4)
- INDEX_W, 5, set-index bits; TAG_W = ADDR_W − INDEX_W − log2(BLOCK_BYTES)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cpuRen / cpuWen  in  1  CPU load / store request, held stable while stall=1
- cpuAddr  in  ADDR_W  byte address (word-aligned)
- cpuWdata  in  32  store data; cpuByteEn  in  4  store byte enables
- cpuRdata  out  32  load data; stall  out  1  pipeline stall
- sramRen, sramWen, sramMemWen  out  1  array read / CPU write / refill write
- sramBytesAccess  out  BLOCK_BYTES  byte mask into block
- sramBlockAddr  out  TAG_W+INDEX_W  {tag,index}
- sramDataIn  out  8*BLOCK_BYTES  write/refill data
- sramHit, sramDirty  in  1  hit / victim-or-hit dirty bit
- sramDataOut  in  8*BLOCK_BYTES  hit block or victim block
- sramVictimTag  in  TAG_W  tag of selected victim
- memReq, memWe  out  1  memory request / write; memAddr  out  ADDR_W  block-aligned
- memWdata  out  8*BLOCK_BYTES; memRdata  in  8*BLOCK_BYTES; memAck  in  1  one-cycle completion pulse
- hitCnt, missCnt  out  32  performance counters (see Configuration)

## Operation
- States: IDLE, WRITEBACK, REFILL, INSTALL. Reset → IDLE.
- IDLE: sramRen=cpuRen&!cpuWen, sramWen=cpuWen&sramHit; sramBlockAddr=cpuAddr[ADDR_W-1:log2 BLOCK_BYTES]. cpuWen has priority if both set.
- Word select w=cpuAddr[log2 BLOCK_BYTES-1:2]; cpuRdata=sramDataOut word w; sramBytesAccess=cpuByteEn<<(4w); sramDataIn=cpuWdata replicated across all words.
- IDLE, request, !sramHit: latch victim block, victim tag, request block address; go WRITEBACK if sramDirty else REFILL.
- WRITEBACK: memReq=1, memWe=1, memAddr={victimTag,index,0}, memWdata=latched victim. On memAck → REFILL.
- REFILL: memReq=1, memWe=0, memAddr=request block address. On memAck latch memRdata → INSTALL.
- INSTALL: sramMemWen=1, sramDataIn=refill buffer, sramBlockAddr=latched address; → IDLE, where the held request replays and hits.
- stall = (cpuRen|cpuWen) & !(state==IDLE & sramHit).
- CPU dropping its request mid-miss: the in-flight sequence still completes through INSTALL.

## Timing
- Reset (async, immediate): state IDLE, memReq=0, memWe=0, all latched regs 0, counters 0; combinational outputs follow IDLE rules.
- Hit: zero added latency, stall=0 same cycle; store commits at that rising edge.
- Clean miss: stall from request cycle; REFILL entered next edge; memAck at edge N → INSTALL → IDLE → hit one cycle later. Total = memory latency + 3 cycles.
- Dirty miss: adds WRITEBACK phase (memory latency + 1).
- memReq/memWe/memAddr/memWdata stable from assertion until the cycle memAck is sampled; memReq drops the cycle after. memAck outside WRITEBACK/REFILL ignored.

## Configuration
- DCACHE_PERF_CNT_EN defined: hitCnt increments on each IDLE hit that is not a post-refill replay; missCnt increments on each IDLE→WRITEBACK/REFILL transition; both wrap at 2^32.
- Undefined: hitCnt=missCnt=0 constant, no counter logic.

## Test plan
- Cold read 0x0000_0040, memory returns 128'h…DDDD_CCCC_BBBB_AAAA after 3 cycles -> REFILL, memReq addr 0x40, memWe=0; INSTALL one cycle; cpuRdata=32'hBBBB_AAAA... word 0; stall deasserts; missCnt=1, hitCnt=0.
- Read 0x44 after above -> hit, stall=0 same cycle, cpuRdata = word 1, hitCnt=1.
- Store 0x48 data 32'h1234_5678 byteEn 4'b0011 on hit -> sramWen=1, sramBytesAccess=16'h0300; later read 0x48 returns low half 16'h5678 merged.
- Dirty conflict miss (victim tag 0x5, same index) -> WRITEBACK to victim address with memWe=1 and dirty block, then REFILL of new address; exact ordering checked.
- rst low during REFILL with memReq=1 -> memReq=0 immediately, state IDLE, counters 0; late memAck ignored.
- Build without DCACHE_PERF_CNT_EN -> hitCnt=missCnt=0 throughout the above.
